reg_bank_mode: RTL and testbench
================================

Name: reg_bank_mode

Overview:
- Parametrised successor to the single 16-bit enabled register: a bank of DEPTH registers, each WIDTH bits wide.
- One write port with four write modes (load, increment, shift-left, clear), two independent read ports, and a carry/overflow flag.
- Sits between the bus (buswires) and the datapath. It replaces discrete enabled-register instances for the general-purpose registers and the PC-style counters.

Parameters:
WIDTH, 16, bits per register (>=2)
DEPTH, 8, number of registers (>=2, need not be a power of 2)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH
REG_READ, 0, 0 = combinational read ports; 1 = registered read ports (1-cycle latency, write-first bypass)

Ports:
clock  in  1  rising-edge clock, single clock domain
resetn  in  1  synchronous, active-low reset, sampled on rising edge of clock
wr_en  in  1  write strobe; operation applied at rising edge when 1
wr_addr  in  ADDR_W  target register index
wr_mode  in  2  00 load, 01 increment, 10 shift-left by 1, 11 clear
buswires  in  WIDTH  load data (used only in mode 00)
rd_addr_a  in  ADDR_W  read port A index
rd_data_a  out  WIDTH  read port A data
rd_addr_b  in  ADDR_W  read port B index
rd_data_b  out  WIDTH  read port B data
carry  out  1  carry/overflow flag of the last accepted write
regs_flat  out  DEPTH*WIDTH  all register contents; reg i occupies bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset:
  - One clock edge with resetn=0 clears all registers to 0 and sets carry=0.
  - When REG_READ=1, it also sets rd_data_a=0 and rd_data_b=0.
  - Reset has priority over wr_en; a write asserted in a reset cycle is discarded.
- Write is accepted at a rising edge when resetn=1, wr_en=1 and wr_addr<DEPTH. It updates reg[wr_addr] only; all other registers hold.
  - 00 load: reg <= buswires; carry <= 0
  - 01 increment: reg <= reg+1 mod 2**WIDTH; carry <= 1 iff old reg was all ones (wraps to 0), else 0
  - 10 shift-left: reg <= {reg[WIDTH-2:0],1'b0}; carry <= old reg[WIDTH-1]
  - 11 clear: reg <= 0; carry <= 0
- wr_en=0: no register changes and carry holds.
- wr_addr>=DEPTH (possible when DEPTH is not a power of 2): write ignored entirely; registers and carry unchanged.
- REG_READ=0:
  - rd_data_x = reg[rd_addr_x] combinationally; 0 latency.
  - A write becomes visible only after the edge that performs it; there is no combinational bypass of buswires.
- REG_READ=1:
  - rd_data_x is registered at each rising edge with resetn=1: it takes the value reg[rd_addr_x] will hold after that edge.
  - Write-first: if the same edge writes rd_addr_x, the new (post-mode) value is captured.
- Both ports may read the same address, or the write address, simultaneously; no conflict, identical data.
- Read address >= DEPTH returns 0 in both read modes.
- regs_flat always reflects the current register state (post-edge), independent of REG_READ.
- Reset asserted mid-sequence, e.g. between increments: next edge forces all state to 0. Operation resumes on the first edge with resetn=1.

Test Plan:
1. Reset then load: resetn=0 for 1 edge -> regs_flat=0, carry=0. Release; write mode 00, addr 3, buswires=16'hA5C3 -> reg3=A5C3, carry=0, rd_addr_a=3 gives A5C3 (REG_READ=0 same cycle after edge).
2. Increment wrap: load reg5=16'hFFFE, increment twice -> reg5=FFFF with carry=0, then reg5=0000 with carry=1. Idle cycle with wr_en=0 -> carry stays 1.
3. Shift-left carry: load reg1=16'h8001, shift -> reg1=0002, carry=1. Shift again -> 0004, carry=0. Clear -> 0000, carry=0.
4. Registered-read bypass (REG_READ=1): reg2=0010 and rd_addr_a=rd_addr_b=2. On the same edge, increment reg2 -> both rd_data ports show 0011 after that edge (not 0010).
5. Reset priority: assert resetn=0 together with wr_en=1, mode 00, addr 0, buswires=1234 -> reg0=0 after the edge. Deassert reset; subsequent load 1234 -> reg0=1234.
6. Out-of-range (DEPTH=6, ADDR_W=3): load to addr 7 -> regs_flat unchanged, carry unchanged. rd_addr_a=6 -> rd_data_a=0.

Source files
------------

// File: rtl/reg_bank_mode_if.sv
// Write/read bus of the mode register bank: one write port, two read ports, flag and full state view.
interface reg_bank_mode_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
);
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [1:0]             wr_mode;
    logic [WIDTH-1:0]       buswires;
    logic [ADDR_W-1:0]      rd_addr_a;
    logic [WIDTH-1:0]       rd_data_a;
    logic [ADDR_W-1:0]      rd_addr_b;
    logic [WIDTH-1:0]       rd_data_b;
    logic                   carry;
    logic [DEPTH*WIDTH-1:0] regs_flat;

    modport master (
        output wr_en, wr_addr, wr_mode, buswires, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, carry, regs_flat
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, buswires, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, carry, regs_flat
    );
endinterface

// File: rtl/reg_bank_mode.sv
// Bank of DEPTH x WIDTH registers with load/increment/shift/clear write modes,
// two read ports (combinational or registered write-first) and a carry flag.
module reg_bank_mode #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int REG_READ = 0
) (
    input logic            clock,
    input logic            resetn,
    reg_bank_mode_if.slave bus
);
    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_INC   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    logic [DEPTH*WIDTH-1:0] regs_q;
    logic [DEPTH*WIDTH-1:0] regs_d;
    logic                   carry_q;
    logic                   carry_d;
    logic                   wr_hit;
    logic [WIDTH-1:0]       old_val;
    logic [WIDTH-1:0]       new_val;

    // Addresses past the last register read as zero, which also covers non-power-of-2 depths.
    function automatic logic [WIDTH-1:0] pick(input logic [DEPTH*WIDTH-1:0] flat,
                                              input logic [ADDR_W-1:0]      addr);
        logic [WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) result = flat[i*WIDTH +: WIDTH];
        end
        return result;
    endfunction

    assign wr_hit  = bus.wr_en && (32'(bus.wr_addr) < DEPTH);
    assign old_val = pick(regs_q, bus.wr_addr);

    always_comb begin
        new_val = '0;
        carry_d = 1'b0;
        case (bus.wr_mode)
            MODE_LOAD:  new_val = bus.buswires;
            MODE_INC:   {carry_d, new_val} = {1'b0, old_val} + {{WIDTH{1'b0}}, 1'b1};
            MODE_SHL:   {carry_d, new_val} = {old_val, 1'b0};
            MODE_CLEAR: new_val = '0;
            default:    new_val = '0;
        endcase
    end

    // Post-edge bank image; the registered read ports sample this for write-first behaviour.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit && (32'(bus.wr_addr) == i)) regs_d[i*WIDTH +: WIDTH] = new_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            regs_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            if (wr_hit) carry_q <= carry_d;
        end
    end

    assign bus.carry     = carry_q;
    assign bus.regs_flat = regs_q;

    generate
        if (REG_READ == 1) begin : g_reg_read
            logic [WIDTH-1:0] rd_q_a;
            logic [WIDTH-1:0] rd_q_b;

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    rd_q_a <= '0;
                    rd_q_b <= '0;
                end else begin
                    rd_q_a <= pick(regs_d, bus.rd_addr_a);
                    rd_q_b <= pick(regs_d, bus.rd_addr_b);
                end
            end

            assign bus.rd_data_a = rd_q_a;
            assign bus.rd_data_b = rd_q_b;
        end else begin : g_comb_read
            assign bus.rd_data_a = pick(regs_q, bus.rd_addr_a);
            assign bus.rd_data_b = pick(regs_q, bus.rd_addr_b);
        end
    endgenerate
endmodule

// File: tb/tb_reg_bank_mode.sv
// Directed bench: a combinational-read bank (DEPTH 8) driven from a vector table, and a
// registered-read bank (DEPTH 6) exercised by hand sequences for bypass, range and reset.
module tb_reg_bank_mode;
    logic clock;
    logic resetn;

    reg_bank_mode_if #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) bus0 ();
    reg_bank_mode_if #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) bus1 ();

    reg_bank_mode #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .REG_READ(0)) dut0 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus0)
    );

    reg_bank_mode #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .REG_READ(1)) dut1 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rstn;
        logic        en;
        logic [2:0]  addr;
        logic [1:0]  mode;
        logic [15:0] data;
        logic [2:0]  rda;
        logic [2:0]  rdb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_c;
    } vec_t;

    vec_t vecs[17];
    int   total;
    int   passed;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Drives one bank's write/read inputs; the other bank gets no write.
    task automatic applyStimulus(input int bank, input logic rstn, input logic en,
                                 input logic [2:0] addr, input logic [1:0] mode,
                                 input logic [15:0] data, input logic [2:0] rda,
                                 input logic [2:0] rdb);
        resetn = rstn;
        if (bank == 0) begin
            bus0.wr_en = en; bus0.wr_addr = addr; bus0.wr_mode = mode; bus0.buswires = data;
            bus0.rd_addr_a = rda; bus0.rd_addr_b = rdb;
            bus1.wr_en = 1'b0;
        end else begin
            bus1.wr_en = en; bus1.wr_addr = addr; bus1.wr_mode = mode; bus1.buswires = data;
            bus1.rd_addr_a = rda; bus1.rd_addr_b = rdb;
            bus0.wr_en = 1'b0;
        end
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        resetn = 1'b0;
        bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_mode = 0; bus0.buswires = 0;
        bus0.rd_addr_a = 0; bus0.rd_addr_b = 0;
        bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_mode = 0; bus1.buswires = 0;
        bus1.rd_addr_a = 0; bus1.rd_addr_b = 0;

        //          name          rstn en  addr  mode   data      rda   rdb   exp_a     exp_b     c
        vecs[0]  = '{"reset",      0, 0, 3'd0, 2'b00, 16'h0000, 3'd0, 3'd3, 16'h0000, 16'h0000, 0};
        vecs[1]  = '{"load3",      1, 1, 3'd3, 2'b00, 16'hA5C3, 3'd3, 3'd3, 16'hA5C3, 16'hA5C3, 0};
        vecs[2]  = '{"load5",      1, 1, 3'd5, 2'b00, 16'hFFFE, 3'd5, 3'd3, 16'hFFFE, 16'hA5C3, 0};
        vecs[3]  = '{"inc5",       1, 1, 3'd5, 2'b01, 16'hAAAA, 3'd5, 3'd5, 16'hFFFF, 16'hFFFF, 0};
        vecs[4]  = '{"inc5wrap",   1, 1, 3'd5, 2'b01, 16'h0000, 3'd5, 3'd5, 16'h0000, 16'h0000, 1};
        vecs[5]  = '{"idle",       1, 0, 3'd5, 2'b01, 16'h0000, 3'd5, 3'd5, 16'h0000, 16'h0000, 1};
        vecs[6]  = '{"load1",      1, 1, 3'd1, 2'b00, 16'h8001, 3'd1, 3'd5, 16'h8001, 16'h0000, 0};
        vecs[7]  = '{"shl1a",      1, 1, 3'd1, 2'b10, 16'h0000, 3'd1, 3'd3, 16'h0002, 16'hA5C3, 1};
        vecs[8]  = '{"shl1b",      1, 1, 3'd1, 2'b10, 16'h0000, 3'd1, 3'd3, 16'h0004, 16'hA5C3, 0};
        vecs[9]  = '{"clear1",     1, 1, 3'd1, 2'b11, 16'hFFFF, 3'd1, 3'd3, 16'h0000, 16'hA5C3, 0};
        vecs[10] = '{"load7",      1, 1, 3'd7, 2'b00, 16'h7FFF, 3'd7, 3'd1, 16'h7FFF, 16'h0000, 0};
        vecs[11] = '{"inc7",       1, 1, 3'd7, 2'b01, 16'h0000, 3'd7, 3'd1, 16'h8000, 16'h0000, 0};
        vecs[12] = '{"shl7",       1, 1, 3'd7, 2'b10, 16'h0000, 3'd7, 3'd1, 16'h0000, 16'h0000, 1};
        vecs[13] = '{"idleload",   1, 0, 3'd7, 2'b00, 16'hFFFF, 3'd7, 3'd1, 16'h0000, 16'h0000, 1};
        vecs[14] = '{"load7b",     1, 1, 3'd7, 2'b00, 16'h1234, 3'd7, 3'd3, 16'h1234, 16'hA5C3, 0};
        vecs[15] = '{"rstprio",    0, 1, 3'd0, 2'b00, 16'h1234, 3'd0, 3'd3, 16'h0000, 16'h0000, 0};
        vecs[16] = '{"loadafter",  1, 1, 3'd0, 2'b00, 16'h1234, 3'd0, 3'd7, 16'h1234, 16'h0000, 0};

        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, vecs[i].rstn, vecs[i].en, vecs[i].addr, vecs[i].mode,
                          vecs[i].data, vecs[i].rda, vecs[i].rdb);
            stepClock();
            checkOutput({vecs[i].name, "_a"}, 128'(bus0.rd_data_a), 128'(vecs[i].exp_a));
            checkOutput({vecs[i].name, "_b"}, 128'(bus0.rd_data_b), 128'(vecs[i].exp_b));
            checkOutput({vecs[i].name, "_c"}, 128'(bus0.carry), 128'(vecs[i].exp_c));
        end
        checkOutput("flat0_after_table", 128'(bus0.regs_flat), 128'({112'h0, 16'h1234}));
        checkOutput("flat1_after_reset", 128'(bus1.regs_flat), 128'(0));
        checkOutput("rd1_after_reset",   128'({bus1.rd_data_a, bus1.rd_data_b}), 128'(0));

        // Combinational read must not see buswires before the write edge.
        applyStimulus(0, 1, 1, 3'd4, 2'b00, 16'hCAFE, 3'd4, 3'd0);
        #1;
        checkOutput("nobypass_pre", 128'(bus0.rd_data_a), 128'(16'h0000));
        stepClock();
        checkOutput("nobypass_post", 128'(bus0.rd_data_a), 128'(16'hCAFE));
        checkOutput("flat0_reg4", 128'(bus0.regs_flat),
                    128'({48'h0, 16'hCAFE, 48'h0, 16'h1234}));

        // Registered read with write-first capture on the written address.
        applyStimulus(1, 1, 1, 3'd2, 2'b00, 16'h0010, 3'd2, 3'd2);
        stepClock();
        checkOutput("rr_load_a", 128'(bus1.rd_data_a), 128'(16'h0010));
        applyStimulus(1, 1, 1, 3'd2, 2'b01, 16'h0000, 3'd2, 3'd2);
        stepClock();
        checkOutput("rr_bypass_a", 128'(bus1.rd_data_a), 128'(16'h0011));
        checkOutput("rr_bypass_b", 128'(bus1.rd_data_b), 128'(16'h0011));
        checkOutput("rr_carry0",   128'(bus1.carry), 128'(0));

        // Address change is only seen after the next edge.
        applyStimulus(1, 1, 0, 3'd2, 2'b00, 16'h0000, 3'd0, 3'd2);
        #1;
        checkOutput("rr_latency_pre", 128'(bus1.rd_data_a), 128'(16'h0011));
        stepClock();
        checkOutput("rr_latency_post", 128'(bus1.rd_data_a), 128'(16'h0000));

        applyStimulus(1, 1, 1, 3'd5, 2'b00, 16'hFFFF, 3'd2, 3'd5);
        stepClock();
        applyStimulus(1, 1, 1, 3'd5, 2'b01, 16'h0000, 3'd2, 3'd5);
        stepClock();
        checkOutput("rr_wrap_b", 128'(bus1.rd_data_b), 128'(16'h0000));
        checkOutput("rr_wrap_c", 128'(bus1.carry), 128'(1));

        // Out-of-range writes and reads on the 6-deep bank.
        applyStimulus(1, 1, 1, 3'd7, 2'b00, 16'hBEEF, 3'd6, 3'd7);
        stepClock();
        checkOutput("oor_flat", 128'(bus1.regs_flat), 128'({48'h0, 16'h0011, 32'h0}));
        checkOutput("oor_carry", 128'(bus1.carry), 128'(1));
        checkOutput("oor_rd_a", 128'(bus1.rd_data_a), 128'(16'h0000));
        checkOutput("oor_rd_b", 128'(bus1.rd_data_b), 128'(16'h0000));
        applyStimulus(1, 1, 1, 3'd6, 2'b11, 16'h0000, 3'd2, 3'd2);
        stepClock();
        checkOutput("oor_clear_carry", 128'(bus1.carry), 128'(1));
        checkOutput("oor_clear_rd", 128'(bus1.rd_data_a), 128'(16'h0011));

        // Reset beats a simultaneous write and clears the registered read data.
        applyStimulus(1, 0, 1, 3'd2, 2'b00, 16'h5555, 3'd2, 3'd2);
        stepClock();
        checkOutput("rr_reset_flat", 128'(bus1.regs_flat), 128'(0));
        checkOutput("rr_reset_rd", 128'({bus1.rd_data_a, bus1.rd_data_b}), 128'(0));
        checkOutput("rr_reset_c", 128'(bus1.carry), 128'(0));
        checkOutput("rr_reset_flat0", 128'(bus0.regs_flat), 128'(0));

        applyStimulus(1, 1, 0, 3'd0, 2'b00, 16'h0000, 3'd0, 3'd0);
        stepClock();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
